// File: rtl/raycast_pkg.sv
// Shared types and default dimensions for the ray column buffer.
//   ray_result_t : 38-bit DDA result as it arrives on the stream
//   ray_entry_t  : 29-bit form kept in the column RAM (column index is the address)
//   wr_state_e   : write-side state (filling the write bank / waiting for sync)
package raycast_pkg;

  localparam int DEF_SCREEN_WIDTH  = 320;
  localparam int DEF_SCREEN_HEIGHT = 180;
  localparam int DEF_TEX_BITS      = 6;

  typedef struct packed {
    logic [8:0]  hcount_ray;
    logic [7:0]  lineHeight;
    logic        wallType;
    logic [3:0]  mapData;
    logic [15:0] wallX;
  } ray_result_t;

  typedef struct packed {
    logic [7:0]  lineHeight;
    logic        wallType;
    logic [3:0]  mapData;
    logic [15:0] wallX;
  } ray_entry_t;

  typedef enum logic {
    WR_FILL = 1'b0,
    WR_FULL = 1'b1
  } wr_state_e;

endpackage

// File: rtl/ray_column_buffer_if.sv
// Ray result stream from the DDA output FIFO into the column buffer.
//   ray_in_tvalid/ray_in_tdata/ray_in_tlast : driven by the producer (master)
//   ray_in_tready                           : driven by the buffer (slave)
interface ray_column_buffer_if;
  import raycast_pkg::*;

  logic        ray_in_tvalid;
  ray_result_t ray_in_tdata;
  logic        ray_in_tlast;
  logic        ray_in_tready;

  modport master (
    output ray_in_tvalid, ray_in_tdata, ray_in_tlast,
    input  ray_in_tready
  );

  modport slave (
    input  ray_in_tvalid, ray_in_tdata, ray_in_tlast,
    output ray_in_tready
  );
endinterface

// File: rtl/ray_col_ram.sv
// Simple dual-port RAM holding both column banks.
//   clk_i                      : clock
//   wr_en_i/wr_addr_i/wr_data_i: write port
//   rd_addr_i/rd_data_o        : read port, data one cycle after address
module ray_col_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 29,
  parameter int AW    = 10
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/ray_column_buffer.sv
// Double-buffered per-column store for DDA results.
//   pixel_clk_in, rst_in (async, active low)
//   ray_s            : ray result stream (slave side)
//   frame_sync_in    : start of vertical blanking, swaps banks once a frame is complete
//   hcount_in/vcount_in/pix_valid_in : pixel lookup request
//   pix_valid_out, wall_hit_out, wallType_out, mapData_out, tex_u_out,
//   row_in_wall_out, lineHeight_out  : lookup result, two cycles after request
//   swap_out         : one-cycle pulse on bank swap
//   drop_count_out   : saturating count of out-of-range column writes
module ray_column_buffer
  import raycast_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int TEX_BITS      = DEF_TEX_BITS
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  ray_column_buffer_if.slave  ray_s,
  input  logic                frame_sync_in,
  input  logic [8:0]          hcount_in,
  input  logic [7:0]          vcount_in,
  input  logic                pix_valid_in,
  output logic                pix_valid_out,
  output logic                wall_hit_out,
  output logic                wallType_out,
  output logic [3:0]          mapData_out,
  output logic [TEX_BITS-1:0] tex_u_out,
  output logic [7:0]          row_in_wall_out,
  output logic [7:0]          lineHeight_out,
  output logic                swap_out,
  output logic [7:0]          drop_count_out
);

  localparam int AW = $clog2(2 * SCREEN_WIDTH);
  localparam logic [AW-1:0]     BANK_OFS = AW'(SCREEN_WIDTH);
  localparam logic [8:0]        COLS     = 9'(SCREEN_WIDTH);
  localparam logic signed [9:0] HGT      = 10'(SCREEN_HEIGHT);

  // ---------------- write side ----------------
  wr_state_e   state_q;
  logic        tready_q;
  logic        bank_q;          // write bank; display bank is the other one
  logic        display_valid_q;
  logic        swap_q;
  logic [7:0]  drop_q;

  ray_result_t beat;
  ray_entry_t  wr_entry;
  logic        hs, col_ok, wr_en;
  logic [AW-1:0] wr_addr;

  assign beat     = ray_s.ray_in_tdata;
  assign hs       = ray_s.ray_in_tvalid & tready_q;
  assign col_ok   = beat.hcount_ray < COLS;
  assign wr_en    = hs & col_ok;
  assign wr_addr  = bank_q ? (BANK_OFS + AW'(beat.hcount_ray)) : AW'(beat.hcount_ray);
  assign wr_entry = '{lineHeight: beat.lineHeight, wallType: beat.wallType,
                      mapData: beat.mapData, wallX: beat.wallX};

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q         <= WR_FILL;
      tready_q        <= 1'b0;
      bank_q          <= 1'b0;
      display_valid_q <= 1'b0;
      swap_q          <= 1'b0;
      drop_q          <= '0;
    end else begin
      swap_q <= 1'b0;
      case (state_q)
        WR_FILL: begin
          tready_q <= 1'b1;
          if (hs) begin
            if (!col_ok && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            // A sync arriving with the closing beat is ignored: the swap
            // waits for the next sync so the display never sees a torn frame.
            if (ray_s.ray_in_tlast) begin
              state_q  <= WR_FULL;
              tready_q <= 1'b0;
            end
          end
        end
        WR_FULL: begin
          tready_q <= 1'b0;
          if (frame_sync_in) begin
            bank_q          <= ~bank_q;
            display_valid_q <= 1'b1;
            swap_q          <= 1'b1;
            tready_q        <= 1'b1;
            state_q         <= WR_FILL;
          end
        end
        default: state_q <= WR_FILL;
      endcase
    end
  end

  assign ray_s.ray_in_tready = tready_q;
  assign swap_out            = swap_q;
  assign drop_count_out      = drop_q;

  // ---------------- read side ----------------
  logic [8:0]    rd_col;
  logic [AW-1:0] rd_addr;
  logic [$bits(ray_entry_t)-1:0] rd_data;
  ray_entry_t    rd_entry;

  // Out-of-range columns read a harmless in-range address; the result is masked.
  assign rd_col   = (hcount_in < COLS) ? hcount_in : 9'd0;
  assign rd_addr  = bank_q ? AW'(rd_col) : (BANK_OFS + AW'(rd_col));
  assign rd_entry = rd_data;

  ray_col_ram #(
    .DEPTH (2 * SCREEN_WIDTH),
    .WIDTH ($bits(ray_entry_t)),
    .AW    (AW)
  ) u_ram (
    .clk_i     (pixel_clk_in),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  logic       s1_valid_q, s1_ok_q;
  logic [7:0] s1_vcount_q;

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid_q  <= 1'b0;
      s1_ok_q     <= 1'b0;
      s1_vcount_q <= '0;
    end else begin
      s1_valid_q  <= pix_valid_in;
      s1_ok_q     <= display_valid_q && (hcount_in < COLS);
      s1_vcount_q <= vcount_in;
    end
  end

  // Wall span: centred on the screen, start may be negative for tall walls.
  logic signed [9:0] lh_s, vc_s, start_u, start_c, h_clamp, row_s;
  logic              span_hit;

  always_comb begin
    lh_s     = signed'({2'b00, rd_entry.lineHeight});
    vc_s     = signed'({2'b00, s1_vcount_q});
    start_u  = (HGT - lh_s) >>> 1;
    h_clamp  = (lh_s < HGT) ? lh_s : HGT;
    start_c  = start_u[9] ? 10'sd0 : start_u;
    row_s    = vc_s - start_u;
    span_hit = (lh_s != 10'sd0) && (vc_s >= start_c) &&
               (vc_s <= start_c + h_clamp - 10'sd1);
  end

  logic unused_rd_bits;
  assign unused_rd_bits = ^{rd_entry.wallX[15-TEX_BITS:0], row_s[9:8]};

  logic                pv_q, hit_q, wt_q;
  logic [3:0]          md_q;
  logic [TEX_BITS-1:0] tex_q;
  logic [7:0]          row_q, lh_q;

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pv_q  <= 1'b0;
      hit_q <= 1'b0;
      wt_q  <= 1'b0;
      md_q  <= '0;
      tex_q <= '0;
      row_q <= '0;
      lh_q  <= '0;
    end else begin
      pv_q <= s1_valid_q;
      if (s1_ok_q) begin
        hit_q <= span_hit;
        wt_q  <= rd_entry.wallType;
        md_q  <= rd_entry.mapData;
        tex_q <= rd_entry.wallX[15 -: TEX_BITS];
        row_q <= row_s[7:0];
        lh_q  <= rd_entry.lineHeight;
      end else begin
        hit_q <= 1'b0;
        wt_q  <= 1'b0;
        md_q  <= '0;
        tex_q <= '0;
        row_q <= '0;
        lh_q  <= '0;
      end
    end
  end

  assign pix_valid_out   = pv_q;
  assign wall_hit_out    = hit_q;
  assign wallType_out    = wt_q;
  assign mapData_out     = md_q;
  assign tex_u_out       = tex_q;
  assign row_in_wall_out = row_q;
  assign lineHeight_out  = lh_q;

endmodule

// File: tb/tb_ray_column_buffer.sv
// Randomized bench for ray_column_buffer with a frame/bank level reference model.
module tb_ray_column_buffer;
  import raycast_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       frame_sync;
  logic [8:0] hcount;
  logic [7:0] vcount;
  logic       pix_valid_in;
  logic       pix_valid_out, wall_hit, wall_type;
  logic [3:0] map_data;
  logic [5:0] tex_u;
  logic [7:0] row_in_wall, line_height, drop_count;
  logic       swap;

  ray_column_buffer_if ifc ();

  ray_column_buffer dut (
    .pixel_clk_in    (clk),
    .rst_in          (rst_n),
    .ray_s           (ifc),
    .frame_sync_in   (frame_sync),
    .hcount_in       (hcount),
    .vcount_in       (vcount),
    .pix_valid_in    (pix_valid_in),
    .pix_valid_out   (pix_valid_out),
    .wall_hit_out    (wall_hit),
    .wallType_out    (wall_type),
    .mapData_out     (map_data),
    .tex_u_out       (tex_u),
    .row_in_wall_out (row_in_wall),
    .lineHeight_out  (line_height),
    .swap_out        (swap),
    .drop_count_out  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Bank contents as the writer left them, which bank is being written,
  // whether a completed frame is waiting for sync, and the drop counter.
  ray_entry_t m_mem [2][320];
  int         m_wbank;
  bit         m_disp_valid;
  bit         m_full;
  int         m_drop;

  typedef struct packed {
    logic       hit;
    logic       wt;
    logic [3:0] md;
    logic [5:0] tex;
    logic [7:0] row;
    logic [7:0] lh;
  } px_t;

  function automatic int floor_half(int d);
    return (d >= 0) ? d / 2 : -((1 - d) / 2);
  endfunction

  // Visible portion of a span of height lh centred on a 180-row screen.
  function automatic px_t model_px(int h, int v);
    px_t p;
    ray_entry_t e;
    int lh, su, top, bot;
    p = '0;
    if (m_disp_valid && h < 320) begin
      e   = m_mem[1 - m_wbank][h];
      lh  = int'(e.lineHeight);
      su  = floor_half(180 - lh);
      top = (su > 0) ? su : 0;
      bot = (su + lh < 180) ? su + lh : 180;
      p.hit = (v >= top) && (v < bot);
      p.row = 8'((v - su) & 255);
      p.wt  = e.wallType;
      p.md  = e.mapData;
      p.tex = e.wallX[15:10];
      p.lh  = e.lineHeight;
    end
    return p;
  endfunction

  function automatic logic [7:0] rand_lh();
    case ($urandom_range(0, 8))
      0: return 8'd0;
      1: return 8'd1;
      2: return 8'd90;
      3: return 8'd179;
      4: return 8'd180;
      5: return 8'd181;
      6: return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One stream beat; leaves tvalid high so beats can run back to back.
  task automatic send_beat(input int hc, input logic [7:0] lh, input logic wt,
                           input logic [3:0] md, input logic [15:0] wx,
                           input bit last, input bit sync_too);
    int waited;
    ray_result_t r;
    bit full_before;
    waited = 0;
    r = '{hcount_ray: 9'(hc), lineHeight: lh, wallType: wt, mapData: md, wallX: wx};
    ifc.ray_in_tvalid = 1'b1;
    ifc.ray_in_tdata  = r;
    ifc.ray_in_tlast  = last;
    while (ifc.ray_in_tready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk_val("tready_fill", 32'(ifc.ray_in_tready), 32'd1);
    if (sync_too) frame_sync = 1'b1;
    full_before = m_full;
    @(posedge clk);
    if (hc < 320) begin
      m_mem[m_wbank][hc] = '{lineHeight: lh, wallType: wt, mapData: md, wallX: wx};
    end else if (m_drop < 255) begin
      m_drop++;
    end
    if (last) m_full = 1'b1;
    #1;
    frame_sync = 1'b0;
    chk_val("drop_count", 32'(drop_count), 32'(m_drop));
    if (sync_too) chk_val("swap_with_tlast", 32'(swap), 32'(full_before));
  endtask

  task automatic end_stream();
    ifc.ray_in_tvalid = 1'b0;
    ifc.ray_in_tlast  = 1'b0;
  endtask

  task automatic pulse_sync(input string name);
    bit exp_swap;
    exp_swap   = m_full;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    end_stream();
    chk_val("swap_pulse", 32'(swap), 32'(exp_swap));
    if (m_full) begin
      m_wbank      = 1 - m_wbank;
      m_disp_valid = 1'b1;
      m_full       = 1'b0;
    end
    chk_val("tready_after_sync", 32'(ifc.ray_in_tready), 32'(!m_full));
    tick();
    chk_val("swap_one_cycle", 32'(swap), 32'd0);
    $display("sync %s: swap=%0b display_bank=%0d", name, exp_swap, 1 - m_wbank);
  endtask

  int req_h[$];
  int req_v[$];
  bit req_vld[$];

  task automatic add_req(input int h, input int v, input bit vld);
    req_h.push_back(h);
    req_v.push_back(v);
    req_vld.push_back(vld);
  endtask

  task automatic add_random_reqs(input int n);
    for (int i = 0; i < n; i++) begin
      add_req(($urandom_range(0, 15) == 0) ? $urandom_range(320, 511) : $urandom_range(0, 319),
              $urandom_range(0, 255), $urandom_range(0, 4) != 0);
    end
  endtask

  // Free-running back-to-back lookups; result of request j is checked two cycles later.
  task automatic run_reads();
    int n;
    px_t p;
    n = req_h.size();
    for (int j = 0; j < n + 2; j++) begin
      if (j >= 2) begin
        chk_val("pix_valid", 32'(pix_valid_out), 32'(req_vld[j-2]));
        if (req_vld[j-2]) begin
          p = model_px(req_h[j-2], req_v[j-2]);
          chk_val("wall_hit", 32'(wall_hit), 32'(p.hit));
          chk_val("wallType", 32'(wall_type), 32'(p.wt));
          chk_val("mapData", 32'(map_data), 32'(p.md));
          chk_val("tex_u", 32'(tex_u), 32'(p.tex));
          chk_val("row_in_wall", 32'(row_in_wall), 32'(p.row));
          chk_val("lineHeight", 32'(line_height), 32'(p.lh));
          $display("read h=%0d v=%0d hit=%0b row=%0d lh=%0d", req_h[j-2], req_v[j-2],
                   wall_hit, row_in_wall, line_height);
        end
      end
      if (j < n) begin
        hcount       = 9'(req_h[j]);
        vcount       = 8'(req_v[j]);
        pix_valid_in = req_vld[j];
      end else begin
        pix_valid_in = 1'b0;
      end
      tick();
    end
    req_h.delete();
    req_v.delete();
    req_vld.delete();
  endtask

  task automatic full_random_frame(input string name);
    for (int c = 0; c < 320; c++) begin
      send_beat(c, rand_lh(), 1'($urandom), 4'($urandom), 16'($urandom), c == 319, 1'b0);
    end
    end_stream();
    $display("frame %s: beats=320 drops=%0d", name, m_drop);
  endtask

  initial begin
    px_t p;
    rst_n = 1'b0;
    frame_sync = 1'b0;
    hcount = '0;
    vcount = '0;
    pix_valid_in = 1'b0;
    ifc.ray_in_tvalid = 1'b0;
    ifc.ray_in_tdata  = '0;
    ifc.ray_in_tlast  = 1'b0;
    m_wbank = 0;
    m_disp_valid = 1'b0;
    m_full = 1'b0;
    m_drop = 0;

    // Reset state
    repeat (3) tick();
    chk_val("tready_in_reset", 32'(ifc.ray_in_tready), 32'd0);
    chk_val("pv_in_reset", 32'(pix_valid_out), 32'd0);
    chk_val("drop_in_reset", 32'(drop_count), 32'd0);
    chk_val("swap_in_reset", 32'(swap), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_val("tready_after_release", 32'(ifc.ray_in_tready), 32'd1);

    // No frame yet: every lookup misses
    add_random_reqs(20);
    run_reads();

    // Frame A: lineHeight 90 everywhere, 200 at column 10
    for (int c = 0; c < 320; c++) begin
      send_beat(c, (c == 10) ? 8'd200 : 8'd90, 1'($urandom), 4'($urandom), 16'($urandom),
                c == 319, 1'b0);
    end
    $display("frame A: beats=320 drops=%0d", m_drop);
    for (int i = 0; i < 4; i++) begin
      chk_val("tready_held_full", 32'(ifc.ray_in_tready), 32'd0);
      tick();
    end
    pulse_sync("A");

    add_req(5, 44, 1); add_req(5, 45, 1); add_req(5, 134, 1); add_req(5, 135, 1);
    add_req(10, 0, 1); add_req(10, 179, 1); add_req(10, 180, 1);
    add_req(320, 90, 1); add_req(511, 0, 1); add_req(7, 90, 0);
    add_random_reqs(40);
    run_reads();

    // Frame B: early sync must not swap; out-of-range beats are dropped
    for (int c = 0; c < 160; c++) begin
      send_beat(c, rand_lh(), 1'($urandom), 4'($urandom), 16'($urandom), 1'b0, 1'b0);
    end
    send_beat(400, 8'd77, 1'b1, 4'hA, 16'hFFFF, 1'b0, 1'b0);
    end_stream();
    pulse_sync("B-early");
    add_req(5, 45, 1); add_req(10, 0, 1);
    add_random_reqs(30);
    run_reads();
    for (int c = 160; c < 320; c++) begin
      send_beat(c, rand_lh(), 1'($urandom), 4'($urandom), 16'($urandom), 1'b0, 1'b0);
    end
    send_beat(450, 8'd12, 1'b0, 4'h3, 16'h1234, 1'b1, 1'b0);
    end_stream();
    $display("frame B: beats=322 drops=%0d", m_drop);
    tick();
    chk_val("tready_after_drop_tlast", 32'(ifc.ray_in_tready), 32'd0);
    pulse_sync("B");
    add_random_reqs(60);
    run_reads();

    // Frame C: partial frame, sync in the same cycle as the tlast beat
    for (int i = 0; i < 50; i++) begin
      send_beat($urandom_range(0, 319), rand_lh(), 1'($urandom), 4'($urandom), 16'($urandom),
                i == 49, i == 49);
    end
    end_stream();
    $display("frame C: beats=50 drops=%0d", m_drop);
    tick();
    chk_val("tready_after_same_cycle", 32'(ifc.ray_in_tready), 32'd0);
    pulse_sync("C");
    add_random_reqs(60);
    run_reads();

    // Frame D: saturate the drop counter, then reset in the middle of filling
    for (int i = 0; i < 260; i++) begin
      send_beat($urandom_range(320, 511), 8'd1, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
    end
    for (int c = 0; c < 100; c++) begin
      send_beat(c, rand_lh(), 1'($urandom), 4'($urandom), 16'($urandom), 1'b0, 1'b0);
    end
    end_stream();
    $display("frame D: beats=360 drops=%0d", m_drop);

    hcount = 9'd5;
    vcount = 8'd90;
    pix_valid_in = 1'b1;
    tick();
    tick();
    p = model_px(5, 90);
    chk_val("pv_before_reset", 32'(pix_valid_out), 32'd1);
    chk_val("lh_before_reset", 32'(line_height), 32'(p.lh));
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("pv_async_reset", 32'(pix_valid_out), 32'd0);
    chk_val("hit_async_reset", 32'(wall_hit), 32'd0);
    chk_val("lh_async_reset", 32'(line_height), 32'd0);
    chk_val("row_async_reset", 32'(row_in_wall), 32'd0);
    chk_val("drop_async_reset", 32'(drop_count), 32'd0);
    chk_val("tready_async_reset", 32'(ifc.ray_in_tready), 32'd0);
    pix_valid_in = 1'b0;
    m_wbank = 0;
    m_disp_valid = 1'b0;
    m_full = 1'b0;
    m_drop = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_val("tready_after_rerelease", 32'(ifc.ray_in_tready), 32'd1);
    add_random_reqs(30);
    run_reads();

    // Frame E: first full frame after reset
    full_random_frame("E");
    pulse_sync("E");
    add_random_reqs(60);
    run_reads();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
